// File: rtl/bpred_pkg.sv
// Shared constants, clear-FSM state type and counter helper for the branch predictor table.
package bpred_pkg;

  localparam logic BPRED_MODE_BIMODAL = 1'b0;
  localparam logic BPRED_MODE_GSHARE  = 1'b1;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic int unsigned weak_taken(input int unsigned counter_width);
    return 32'd1 << (counter_width - 1);
  endfunction

endpackage

// File: rtl/bpred_gshare_table_sat_counter.sv
// Next-state logic for one saturating up/down counter.
// Purely combinational; no flow control.
module sat_counter_next
  import bpred_pkg::*;
#(
  parameter int COUNTER_WIDTH = 2
) (
  input  logic [COUNTER_WIDTH-1:0] cnt_cur,
  input  logic                     outcome,
  output logic [COUNTER_WIDTH-1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt_cur;
    if (outcome == TAKEN) begin
      if (cnt_cur != '1) cnt_nxt = cnt_cur + COUNTER_WIDTH'(1);
    end else begin
      if (cnt_cur != '0) cnt_nxt = cnt_cur - COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/bpred_gshare_table.sv
// Bimodal/gshare saturating-counter predictor with speculative GHR and sequential clear.
// Lookup is 0-cycle combinational, updates land at the next edge; no backpressure, o_Busy flags a clear.
module bpred_gshare_table
  import bpred_pkg::*;
#(
  parameter int BPRED_WIDTH   = 9,
  parameter int COUNTER_WIDTH = 2,
  parameter int GHR_WIDTH     = 9
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Mode,
  input  logic                   i_Lookup_Valid,
  input  logic [BPRED_WIDTH-1:0] i_Index,
  output logic                   o_Prediction,
  output logic [BPRED_WIDTH-1:0] o_Lookup_Index,
  output logic [GHR_WIDTH-1:0]   o_GHR_Snapshot,
  input  logic                   i_ALU_Branch_Valid,
  input  logic [BPRED_WIDTH-1:0] i_Resolution_Index,
  input  logic                   i_ALU_Branch_Outcome,
  input  logic                   i_Mispredict,
  input  logic [GHR_WIDTH-1:0]   i_Resolution_GHR,
  input  logic                   i_Clear,
  output logic                   o_Busy
);

  localparam int DEPTH = 2 ** BPRED_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] WEAK = COUNTER_WIDTH'(weak_taken(COUNTER_WIDTH));

  logic [COUNTER_WIDTH-1:0] cnt_q [DEPTH];
  logic [GHR_WIDTH-1:0]     ghr_q;
  logic [BPRED_WIDTH-1:0]   clr_ptr_q;
  clr_state_t               state_q;
  logic                     busy_q;
  logic [BPRED_WIDTH-1:0]   lookup_idx;
  logic                     pred;
  logic [COUNTER_WIDTH-1:0] res_cnt_nxt;

  assign lookup_idx = (i_Mode == BPRED_MODE_GSHARE) ? (i_Index ^ BPRED_WIDTH'(ghr_q)) : i_Index;
  assign pred       = busy_q ? TAKEN : cnt_q[lookup_idx][COUNTER_WIDTH-1];

  assign o_Prediction   = pred;
  assign o_Lookup_Index = lookup_idx;
  assign o_GHR_Snapshot = ghr_q;
  assign o_Busy         = busy_q;

  sat_counter_next #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_res_cnt (
    .cnt_cur (cnt_q[i_Resolution_Index]),
    .outcome (i_ALU_Branch_Outcome),
    .cnt_nxt (res_cnt_nxt)
  );

  // Clearing walks the table one entry per cycle; resolutions only write while idle.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= WEAK;
    end else if (state_q == CLEAR) begin
      cnt_q[clr_ptr_q] <= WEAK;
    end else if (i_ALU_Branch_Valid) begin
      cnt_q[i_Resolution_Index] <= res_cnt_nxt;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      clr_ptr_q <= '0;
      ghr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Recovery overrides the speculative shift of a same-cycle lookup.
          if (i_ALU_Branch_Valid && i_Mispredict)
            ghr_q <= GHR_WIDTH'({i_Resolution_GHR, i_ALU_Branch_Outcome});
          else if (i_Lookup_Valid)
            ghr_q <= GHR_WIDTH'({ghr_q, pred});
          if (i_Clear) begin
            state_q   <= CLEAR;
            busy_q    <= 1'b1;
            clr_ptr_q <= '0;
            ghr_q     <= '0;
          end
        end
        CLEAR: begin
          if (clr_ptr_q == '1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_ptr_q <= clr_ptr_q + BPRED_WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpred_gshare_table.sv
// Self-checking bench: directed vector table, clear/reset sequences, random traffic vs a reference model.
module tb_bpred_gshare_table;

  localparam int BW     = 9;
  localparam int CW     = 2;
  localparam int GW     = 9;
  localparam int DEPTH  = 512;
  localparam int GDEPTH = 512;
  localparam int WEAK   = 2;
  localparam int CMAX   = 3;

  logic          i_Clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Mode = 1'b0;
  logic          i_Lookup_Valid = 1'b0;
  logic [BW-1:0] i_Index = '0;
  logic          o_Prediction;
  logic [BW-1:0] o_Lookup_Index;
  logic [GW-1:0] o_GHR_Snapshot;
  logic          i_ALU_Branch_Valid = 1'b0;
  logic [BW-1:0] i_Resolution_Index = '0;
  logic          i_ALU_Branch_Outcome = 1'b0;
  logic          i_Mispredict = 1'b0;
  logic [GW-1:0] i_Resolution_GHR = '0;
  logic          i_Clear = 1'b0;
  logic          o_Busy;

  bpred_gshare_table #(
    .BPRED_WIDTH(BW),
    .COUNTER_WIDTH(CW),
    .GHR_WIDTH(GW)
  ) dut (
    .i_Clk                (i_Clk),
    .i_Reset              (i_Reset),
    .i_Mode               (i_Mode),
    .i_Lookup_Valid       (i_Lookup_Valid),
    .i_Index              (i_Index),
    .o_Prediction         (o_Prediction),
    .o_Lookup_Index       (o_Lookup_Index),
    .o_GHR_Snapshot       (o_GHR_Snapshot),
    .i_ALU_Branch_Valid   (i_ALU_Branch_Valid),
    .i_Resolution_Index   (i_Resolution_Index),
    .i_ALU_Branch_Outcome (i_ALU_Branch_Outcome),
    .i_Mispredict         (i_Mispredict),
    .i_Resolution_GHR     (i_Resolution_GHR),
    .i_Clear              (i_Clear),
    .o_Busy               (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: plain integer counters, history as an integer, clear as a countdown.
  int m_cnt [DEPTH];
  int m_ghr;
  int m_busy;
  int m_ptr;

  logic          s_pred;
  logic [BW-1:0] s_lidx;
  logic [GW-1:0] s_ghr;
  logic          s_busy;

  typedef struct {
    int md, lv, ix, bv, ri, oc, mis, rg;
    int ep, elidx, eghr;
  } vec_t;

  vec_t vt [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_cnt[i] = WEAK;
    m_ghr  = 0;
    m_busy = 0;
    m_ptr  = 0;
  endtask

  task automatic step(input int md, input int lv, input int ix, input int bv, input int ri,
                      input int oc, input int mis, input int rg, input int clr);
    int idx;
    int pred;
    @(negedge i_Clk);
    i_Mode               = (md != 0);
    i_Lookup_Valid       = (lv != 0);
    i_Index              = BW'(ix);
    i_ALU_Branch_Valid   = (bv != 0);
    i_Resolution_Index   = BW'(ri);
    i_ALU_Branch_Outcome = (oc != 0);
    i_Mispredict         = (mis != 0);
    i_Resolution_GHR     = GW'(rg);
    i_Clear              = (clr != 0);
    #1;
    idx  = (md != 0) ? ((ix ^ m_ghr) % DEPTH) : (ix % DEPTH);
    pred = (m_busy != 0) ? 1 : ((m_cnt[idx] >= WEAK) ? 1 : 0);
    s_pred = o_Prediction;
    s_lidx = o_Lookup_Index;
    s_ghr  = o_GHR_Snapshot;
    s_busy = o_Busy;
    chk("model_pred", 32'(s_pred), 32'(pred));
    chk("model_lidx", 32'(s_lidx), 32'(idx));
    chk("model_ghr",  32'(s_ghr),  32'(m_ghr));
    chk("model_busy", 32'(s_busy), 32'(m_busy));
    @(posedge i_Clk);
    if (m_busy != 0) begin
      m_cnt[m_ptr] = WEAK;
      m_ptr++;
      if (m_ptr == DEPTH) m_busy = 0;
    end else begin
      if (bv != 0) begin
        if (oc != 0) m_cnt[ri] = (m_cnt[ri] < CMAX) ? m_cnt[ri] + 1 : CMAX;
        else         m_cnt[ri] = (m_cnt[ri] > 0)    ? m_cnt[ri] - 1 : 0;
      end
      if (bv != 0 && mis != 0) m_ghr = (rg * 2 + oc) % GDEPTH;
      else if (lv != 0)        m_ghr = (m_ghr * 2 + pred) % GDEPTH;
      if (clr != 0) begin
        m_busy = 1;
        m_ptr  = 0;
        m_ghr  = 0;
      end
    end
  endtask

  task automatic idle_step(input int md, input int ix);
    step(md, 0, ix, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset is raised mid-cycle so it is seen as asynchronous, and checked before any edge.
  task automatic do_reset();
    @(negedge i_Clk);
    #2;
    i_Reset = 1'b1;
    i_Clear = 1'b0;
    i_ALU_Branch_Valid = 1'b0;
    i_Lookup_Valid = 1'b0;
    i_Mode  = 1'b0;
    i_Index = '0;
    #1;
    model_reset();
    chk("rst_pred_idx0", 32'(o_Prediction), 32'd1);
    chk("rst_ghr",       32'(o_GHR_Snapshot), 32'd0);
    chk("rst_busy",      32'(o_Busy), 32'd0);
    i_Index = BW'(DEPTH - 1);
    #1;
    chk("rst_pred_idx511", 32'(o_Prediction), 32'd1);
    @(negedge i_Clk);
    i_Reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int guard;
    // md lv ix bv ri oc mis rg | pred lidx ghr
    vt[0]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    vt[1]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    vt[5]  = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0};
    vt[6]  = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0};
    vt[7]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vt[9]  = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0};
    vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vt[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[12] = '{0, 0, 2, 1, 2, 0, 0, 0, 1, 2, 0};
    vt[13] = '{0, 0, 2, 0, 0, 0, 0, 0, 0, 2, 0};
    vt[14] = '{1, 0, 5, 1, 5, 0, 0, 0, 1, 5, 0};
    vt[15] = '{1, 0, 5, 1, 5, 0, 0, 0, 0, 5, 0};
    vt[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vt[17] = '{1, 1, 4, 0, 0, 0, 0, 0, 0, 5, 1};
    vt[18] = '{1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 2};
    vt[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5};
    vt[20] = '{1, 1, 0, 1, 9, 0, 1, 3, 0, 5, 5};
    vt[21] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 6};
    vt[22] = '{0, 0, 9, 0, 0, 0, 0, 0, 0, 9, 6};

    model_reset();
    do_reset();

    for (int i = 0; i < 23; i++) begin
      step(vt[i].md, vt[i].lv, vt[i].ix, vt[i].bv, vt[i].ri, vt[i].oc, vt[i].mis, vt[i].rg, 0);
      chk($sformatf("vec%0d_pred", i), 32'(s_pred), 32'(vt[i].ep));
      chk($sformatf("vec%0d_lidx", i), 32'(s_lidx), 32'(vt[i].elidx));
      chk($sformatf("vec%0d_ghr", i),  32'(s_ghr),  32'(vt[i].eghr));
    end

    // Clear: drive counter 7 to 0, clear with a same-cycle resolution and lookup, hammer it while busy.
    step(0, 0, 7, 1, 7, 0, 0, 0, 0);
    step(0, 0, 7, 1, 7, 0, 0, 0, 0);
    idle_step(0, 7);
    chk("pre_clear_idx7", 32'(s_pred), 32'd0);
    step(0, 1, 0, 1, 8, 0, 1, 'h55, 1);
    busy_cnt = 0;
    for (int c = 0; c < 700; c++) begin
      step(1, 1, int'($urandom_range(0, 511)), m_busy, 7, 0, 1, int'($urandom_range(0, 511)), m_busy);
      if (s_busy !== 1'b1) break;
      busy_cnt++;
      if (s_pred !== 1'b1 || s_ghr !== '0) chk("clear_pred_ghr", {31'd0, s_pred}, 32'd1);
    end
    chk("clear_busy_len", 32'(busy_cnt), 32'd512);
    idle_step(0, 7);
    chk("post_clear_idx7", 32'(s_pred), 32'd1);
    idle_step(0, 5);
    chk("post_clear_idx5", 32'(s_pred), 32'd1);

    for (int n = 0; n < 2000; n++) begin
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0,
           int'($urandom_range(0, 511)), ($urandom_range(0, 499) == 0) ? 1 : 0);
    end

    guard = 0;
    while (m_busy != 0 && guard < 600) begin
      idle_step(0, 0);
      guard++;
    end
    chk("random_phase_idle", 32'(m_busy), 32'd0);

    // Reset 100 cycles into a clear, with entry 511 left non-weak beforehand.
    step(0, 0, 511, 1, 511, 0, 0, 0, 0);
    step(0, 0, 511, 1, 511, 0, 0, 0, 0);
    idle_step(0, 511);
    chk("pre_reset_idx511", 32'(s_pred), 32'd0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 99; c++) idle_step(0, 511);
    chk("busy_before_reset", 32'(s_busy), 32'd1);
    do_reset();
    idle_step(0, 511);
    chk("after_reset_idx511", 32'(s_pred), 32'd1);
    chk("after_reset_busy", 32'(s_busy), 32'd0);
    step(1, 1, 3, 0, 0, 0, 0, 0, 0);
    idle_step(1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
